// File: rtl/uart_echo_tester_pkg.sv
// Shared definitions for the UART echo link tester: FSM encoding and helpers.
package uart_echo_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TX,
    ST_LOAD,
    ST_WAIT_RX,
    ST_CAPTURE,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 200000;

  // Width of the timeout counter; it only has to hold TIMEOUT_CYCLES-1.
  function automatic int unsigned tmo_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  // Error counter increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_echo_timeout.sv
// Loadable down-counter with synchronous clear; expired while the count is zero.
module uart_echo_timeout #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Count register: clear beats load, load beats decrement, stop at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/uart_echo_tester.sv
// Initiator side of the UART echo link: sends SEED, SEED+1, ... and checks the echoes.
module uart_echo_tester
  import uart_echo_tester_pkg::*;
#(
  parameter int unsigned NUM_BYTES      = 16,
  parameter logic [7:0]  SEED           = 8'h01,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       ld_tx_data,
  output logic [7:0] tx_data,
  input  logic       tx_empty,
  output logic       uld_rx_data,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout_seen,
  output logic [7:0] err_count,
  output logic [7:0] last_rx
);

  localparam int unsigned      TMO_W    = tmo_width(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       LAST_IDX = 8'(NUM_BYTES - 1);

  state_t     state, state_n;
  logic [7:0] idx;
  logic       run_start, tmo_load, tmo_hit, capture, advance, finish;
  logic       tmo_expired;

  uart_echo_timeout #(
    .WIDTH (TMO_W)
  ) u_timeout (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (run_start),
    .load       (tmo_load),
    .load_value (TMO_LOAD),
    .enable     (state == ST_WAIT_RX),
    .expired    (tmo_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic, uart handshakes and datapath strobes.
  always_comb begin
    state_n     = state;
    ld_tx_data  = 1'b0;
    uld_rx_data = 1'b0;
    run_start   = 1'b0;
    tmo_load    = 1'b0;
    tmo_hit     = 1'b0;
    capture     = 1'b0;
    advance     = 1'b0;
    finish      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          run_start = 1'b1;
          state_n   = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (tx_empty) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        ld_tx_data = 1'b1;
        if (!tx_empty) begin
          tmo_load = 1'b1;
          state_n  = ST_WAIT_RX;
        end
      end
      ST_WAIT_RX: begin
        if (!rx_empty) begin
          uld_rx_data = 1'b1;
          state_n     = ST_CAPTURE;
        end else if (tmo_expired) begin
          tmo_hit = 1'b1;
          state_n = ST_NEXT;
        end
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        state_n = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx == LAST_IDX) begin
          state_n = ST_DONE;
        end else begin
          advance = 1'b1;
          state_n = ST_WAIT_TX;
        end
      end
      ST_DONE: begin
        finish  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Run datapath: byte index, transmitted byte, captured byte and run status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx          <= '0;
      tx_data      <= '0;
      last_rx      <= '0;
      err_count    <= '0;
      timeout_seen <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
    end else begin
      if (run_start) begin
        idx          <= '0;
        tx_data      <= SEED;
        err_count    <= '0;
        timeout_seen <= 1'b0;
        busy         <= 1'b1;
        done         <= 1'b0;
        pass         <= 1'b0;
      end
      if (tmo_hit) begin
        timeout_seen <= 1'b1;
        err_count    <= sat_inc8(err_count);
      end
      if (capture) begin
        last_rx <= rx_data;
        if (rx_data != tx_data) err_count <= sat_inc8(err_count);
      end
      if (advance) begin
        idx     <= idx + 8'd1;
        tx_data <= tx_data + 8'd1;
      end
      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_count == '0);
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_tester.sv
// Directed bench for uart_echo_tester with a behavioural uart/echo model and a tx scoreboard.
module tb_uart_echo_tester;

  localparam int TX_TIME    = 20;
  localparam int ECHO_DELAY = 50;
  localparam int LATE_DELAY = 150;
  localparam int RUN_BUDGET = 3000;

  typedef struct {
    longint     due;
    logic [7:0] b;
  } echo_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  bit         sel = 1'b0;

  logic       tx_empty, rx_empty;
  logic [7:0] rx_data, rx_buf;

  logic       ld_a, uld_a, busy_a, done_a, pass_a, tmo_a;
  logic [7:0] txd_a, err_a, lrx_a;
  logic       ld_b, uld_b, busy_b, done_b, pass_b, tmo_b;
  logic [7:0] txd_b, err_b, lrx_b;

  logic       ld_m, uld_m, busy_m, done_m, pass_m, tmo_m;
  logic [7:0] txd_m, err_m, lrx_m;

  assign ld_m   = sel ? ld_b   : ld_a;
  assign uld_m  = sel ? uld_b  : uld_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign done_m = sel ? done_b : done_a;
  assign pass_m = sel ? pass_b : pass_a;
  assign tmo_m  = sel ? tmo_b  : tmo_a;
  assign txd_m  = sel ? txd_b  : txd_a;
  assign err_m  = sel ? err_b  : err_a;
  assign lrx_m  = sel ? lrx_b  : lrx_a;

  always #5 clk = ~clk;

  uart_echo_tester #(
    .NUM_BYTES      (4),
    .SEED           (8'h10),
    .TIMEOUT_CYCLES (100)
  ) dut_a (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start_a),
    .ld_tx_data   (ld_a),
    .tx_data      (txd_a),
    .tx_empty     (tx_empty),
    .uld_rx_data  (uld_a),
    .rx_data      (rx_data),
    .rx_empty     (rx_empty),
    .busy         (busy_a),
    .done         (done_a),
    .pass         (pass_a),
    .timeout_seen (tmo_a),
    .err_count    (err_a),
    .last_rx      (lrx_a)
  );

  uart_echo_tester #(
    .NUM_BYTES      (4),
    .SEED           (8'hFE),
    .TIMEOUT_CYCLES (100)
  ) dut_b (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start_b),
    .ld_tx_data   (ld_b),
    .tx_data      (txd_b),
    .tx_empty     (tx_empty),
    .uld_rx_data  (uld_b),
    .rx_data      (rx_data),
    .rx_empty     (rx_empty),
    .busy         (busy_b),
    .done         (done_b),
    .pass         (pass_b),
    .timeout_seen (tmo_b),
    .err_count    (err_b),
    .last_rx      (lrx_b)
  );

  // Scoreboard queues and echo-model configuration.
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  echo_t      echo_q[$];
  echo_t      e;
  int         xor_idx  = -1;
  int         drop_idx = -1;
  int         late_idx = -1;
  int         load_no, tx_cnt, uld_double;
  longint     cyc;
  logic       uld_prev;

  // Uart + far-end echo model: accepts loads, returns each byte after a delay.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_empty   <= 1'b1;
      rx_empty   <= 1'b1;
      rx_data    <= '0;
      rx_buf     <= '0;
      tx_cnt     <= 0;
      load_no    <= 0;
      uld_prev   <= 1'b0;
      uld_double <= 0;
      cyc        <= 0;
      echo_q.delete();
      obs_q.delete();
    end else begin
      cyc      <= cyc + 1;
      uld_prev <= uld_m;
      if (uld_m && uld_prev) uld_double <= uld_double + 1;
      if (!busy_m) load_no <= 0;
      if (!tx_empty) begin
        if (tx_cnt == 0) tx_empty <= 1'b1;
        else tx_cnt <= tx_cnt - 1;
      end else if (ld_m) begin
        tx_empty <= 1'b0;
        tx_cnt   <= TX_TIME - 1;
        load_no  <= load_no + 1;
        obs_q.push_back(txd_m);
        if (load_no != drop_idx) begin
          e.due = cyc + longint'((load_no == late_idx) ? LATE_DELAY : ECHO_DELAY);
          e.b   = txd_m ^ ((load_no == xor_idx) ? 8'h01 : 8'h00);
          echo_q.push_back(e);
        end
      end
      if (uld_m) begin
        rx_data  <= rx_buf;
        rx_empty <= 1'b1;
      end else if (rx_empty && (echo_q.size() > 0) && (cyc >= echo_q[0].due)) begin
        rx_buf   <= echo_q[0].b;
        rx_empty <= 1'b0;
        void'(echo_q.pop_front());
      end
    end
  end

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit side);
    @(negedge clk);
    if (side) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic begin_run(input bit side, input logic [7:0] seed, input string tag);
    for (int k = 0; k < 4; k++) exp_q.push_back(seed + 8'(k));
    sel = side;
    pulse_start(side);
    check1({tag, "_busy_on_start"}, busy_m, 1'b1);
    check1({tag, "_done_cleared"}, done_m, 1'b0);
  endtask

  task automatic finish_run(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < RUN_BUDGET; i++) begin
      @(negedge clk);
      if (done_m) begin
        ok = 1'b1;
        break;
      end
    end
    check1({tag, "_done_within_budget"}, ok, 1'b1);
    check1({tag, "_busy_off"}, busy_m, 1'b0);
    check32({tag, "_tx_count"}, obs_q.size(), exp_q.size());
    while ((exp_q.size() > 0) && (obs_q.size() > 0))
      check8({tag, "_tx_byte"}, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_status(input string tag, input logic p, input logic t,
                              input logic [7:0] err, input logic [7:0] lrx);
    check1({tag, "_pass"}, pass_m, p);
    check1({tag, "_timeout_seen"}, tmo_m, t);
    check8({tag, "_err_count"}, err_m, err);
    check8({tag, "_last_rx"}, lrx_m, lrx);
  endtask

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state of both instances.
    check8("reset_a_ctrl", {2'b00, ld_a, uld_a, busy_a, done_a, pass_a, tmo_a}, 8'h00);
    check8("reset_a_err", err_a, 8'h00);
    check8("reset_a_last_rx", lrx_a, 8'h00);
    check8("reset_a_tx_data", txd_a, 8'h00);
    check8("reset_b_ctrl", {2'b00, ld_b, uld_b, busy_b, done_b, pass_b, tmo_b}, 8'h00);

    // Ideal echo.
    begin_run(1'b0, 8'h10, "ideal");
    finish_run("ideal");
    check_status("ideal", 1'b1, 1'b0, 8'h00, 8'h13);
    repeat (5) @(negedge clk);
    check1("ideal_done_held", done_m, 1'b1);
    check1("ideal_pass_held", pass_m, 1'b1);

    // Byte 2 corrupted by the echo.
    xor_idx = 2;
    begin_run(1'b0, 8'h10, "xor");
    finish_run("xor");
    check_status("xor", 1'b0, 1'b0, 8'h01, 8'h13);
    xor_idx = -1;

    // Byte 1 never echoed.
    drop_idx = 1;
    begin_run(1'b0, 8'h10, "drop");
    finish_run("drop");
    check_status("drop", 1'b0, 1'b1, 8'h01, 8'h13);
    drop_idx = -1;

    // Second start mid-run is ignored.
    begin_run(1'b0, 8'h10, "restart");
    repeat (10) @(negedge clk);
    pulse_start(1'b0);
    finish_run("restart");
    check_status("restart", 1'b1, 1'b0, 8'h00, 8'h13);

    // Seed wraps through FF -> 00.
    begin_run(1'b1, 8'hFE, "wrap");
    finish_run("wrap");
    check_status("wrap", 1'b1, 1'b0, 8'h00, 8'h01);

    // Byte 1 echoed after its timeout: it is unloaded by byte 2, byte 2's echo by byte 3.
    late_idx = 1;
    begin_run(1'b0, 8'h10, "late");
    finish_run("late");
    check_status("late", 1'b0, 1'b1, 8'h03, 8'h12);
    check32("uld_single_cycle", uld_double, 0);
    late_idx = -1;

    // Reset asserted while in LOAD aborts asynchronously.
    sel = 1'b0;
    pulse_start(1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ld_a) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check1("abort_reached_load", ok, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check1("abort_ld_drops", ld_a, 1'b0);
    check1("abort_busy", busy_a, 1'b0);
    check1("abort_done", done_a, 1'b0);
    check8("abort_err", err_a, 8'h00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    begin_run(1'b0, 8'h10, "after_abort");
    finish_run("after_abort");
    check_status("after_abort", 1'b1, 1'b0, 8'h00, 8'h13);
    check32("uld_single_cycle_final", uld_double, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_echo_tester.md
Name: uart_echo_tester

Overview:
- Initiator side of the UART echo link: drives the uart core's transmit and receive handshakes from the far end of a loopback target.
- Sends a programmed sequence of bytes and waits for each byte to be echoed back.
- Compares each echoed byte with the byte sent, counts mismatches and timeouts, and reports pass/fail.
- Sits beside a uart instance in a board-level test top, in place of the echo state machine.

Parameters:
- NUM_BYTES, 16, bytes per run (1..255)
- SEED, 8'h01, first byte sent; byte k = SEED + k, modulo 256
- TIMEOUT_CYCLES, 200000, clk cycles allowed between load and echo receipt (>= 2)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a run; ignored while busy
- ld_tx_data  output  1  uart load request; held high until tx_empty drops
- tx_data  output  8  byte to transmit
- tx_empty  input  1  uart transmitter idle
- uld_rx_data  output  1  one-cycle uart unload pulse
- rx_data  input  8  uart received byte, valid the cycle after uld_rx_data
- rx_empty  input  1  low when the uart holds a received byte
- busy  output  1  run in progress
- done  output  1  run finished; held until the next accepted start
- pass  output  1  done and err_count == 0
- timeout_seen  output  1  sticky, set if any byte timed out in this run
- err_count  output  8  mismatches plus timeouts, saturating at 255
- last_rx  output  8  most recent byte captured from rx_data

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0, internal counters 0.
- IDLE: on start, go to WAIT_TX. Clear err_count, timeout_seen, done and the byte index. Set tx_data = SEED. Set busy = 1.
- WAIT_TX: when tx_empty = 1, set ld_tx_data = 1 and go to LOAD.
- LOAD: hold ld_tx_data high. When tx_empty = 0, set ld_tx_data = 0, clear the timeout counter and go to WAIT_RX.
- WAIT_RX: when rx_empty = 0, assert uld_rx_data for exactly one cycle and go to CAPTURE.
- WAIT_RX timeout: if the counter reaches TIMEOUT_CYCLES-1 with rx_empty still 1, increment err_count (saturating), set timeout_seen and go to NEXT.
- CAPTURE: register rx_data into last_rx. If it differs from tx_data, increment err_count (saturating). Go to NEXT.
- NEXT: if index == NUM_BYTES-1, go to DONE. Otherwise increment the index, set tx_data = tx_data + 1 (wraps FF to 00) and go to WAIT_TX.
- DONE: busy = 0, done = 1, pass = (err_count == 0). Return to IDLE in the same cycle and keep done/pass/err_count visible there.
- start asserted while busy is ignored.
- A start pulse coincident with the DONE cycle is ignored. Only a start seen in IDLE is accepted.
- A byte that arrives after its own timeout is left unread. The next WAIT_RX unloads it, so it is counted as a mismatch. This is the intended behaviour and the bench checks for it.
- rx_empty going low before ld_tx_data is issued (stale byte) is not flushed. It is consumed by the next WAIT_RX.
- reset_n low mid-run aborts immediately: ld_tx_data and uld_rx_data drop asynchronously and all status clears.
- Run latency per byte: 2 cycles of handshake overhead plus the uart transmit time plus the echo delay.

Decomposition:
- Shared package: the state encoding (IDLE, WAIT_TX, LOAD, WAIT_RX, CAPTURE, NEXT, DONE) and the width constant for the timeout counter, $clog2(TIMEOUT_CYCLES).
- One natural sub-module: uart_echo_timeout. It is a loadable down-counter with clear and expired outputs, reusable by other link testers.

Test Plan:
- Ideal echo model (byte returned 50 cycles after tx_empty falls), NUM_BYTES=4, SEED=8'h10 -> tx sequence 10,11,12,13; done=1, pass=1, err_count=0, last_rx=8'h13.
- Echo model XORs byte 2 with 8'h01 -> err_count=1, pass=0, timeout_seen=0, last_rx=8'h13.
- Echo model drops byte 1, TIMEOUT_CYCLES=100 -> timeout_seen=1, err_count=1, run still completes with done=1.
- SEED=8'hFE, NUM_BYTES=4 -> tx sequence FE,FF,00,01; pass=1.
- start pulsed again 10 cycles into a run -> no restart; sequence and err_count unaffected.
- reset_n low while in LOAD -> ld_tx_data=0 in the same cycle, busy=0, done=0; a new start after release gives a clean pass.
